// File: rtl/gpio_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gpio_port                                                     |
// | Purpose  : WIDTH-bit memory-mapped GPIO with direction control, 2-flop   |
// |            input sync and per-pin edge interrupts (mask/polarity/W1C).   |
// |            Optional input debounce when GPIO_DEBOUNCE_EN is defined.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gpio_port #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] OUT_RESET  = '0,
  parameter int               DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_valid,
  output logic             bus_ready,
  input  logic [4:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic [3:0]       bus_wstrb,
  output logic [31:0]      bus_rdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  localparam logic [2:0] c_A_OUT    = 3'd0;
  localparam logic [2:0] c_A_DIR    = 3'd1;
  localparam logic [2:0] c_A_IN     = 3'd2;
  localparam logic [2:0] c_A_MASK   = 3'd3;
  localparam logic [2:0] c_A_EDGE   = 3'd4;
  localparam logic [2:0] c_A_STATUS = 3'd5;

  logic [WIDTH-1:0] r_out, r_dir, r_mask, r_edge, r_status;
  logic             r_ready, r_irq;
  logic [31:0]      r_rdata;
  logic [WIDTH-1:0] r_sync1, r_sync2, r_prev;
  logic [1:0]       r_fill;
  logic             r_primed;

  logic [WIDTH-1:0] w_cur;
  logic             w_cur_vld;
  logic [WIDTH-1:0] w_rise, w_fall, w_event;
  logic             w_accept, w_write;
  logic [2:0]       w_sel;
  logic [31:0]      w_bmask32;
  logic [WIDTH-1:0] w_wmask, w_wdata, w_w1c;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_sel     = bus_addr[4:2];
  assign w_accept  = bus_valid & ~r_ready;
  assign w_write   = w_accept & (|bus_wstrb);
  assign w_bmask32 = {{8{bus_wstrb[3]}}, {8{bus_wstrb[2]}}, {8{bus_wstrb[1]}}, {8{bus_wstrb[0]}}};
  assign w_wmask   = w_bmask32[WIDTH-1:0];
  assign w_wdata   = bus_wdata[WIDTH-1:0];
  assign w_w1c     = (w_write && (w_sel == c_A_STATUS)) ? (w_wdata & w_wmask) : '0;
  assign w_unused  = ^{bus_addr[1:0], bus_wdata, w_bmask32};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] new_v,
                                             input logic [WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // r_fill tracks how far valid samples have propagated after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_fill   <= '0;
      r_primed <= 1'b0;
    end else begin
      r_sync1  <= pin_in;
      r_sync2  <= r_sync1;
      r_prev   <= w_cur;
      r_fill   <= {r_fill[0], 1'b1};
      r_primed <= r_primed | w_cur_vld;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int                 c_CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

  logic r_cur_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cur_vld <= 1'b0;
    else       r_cur_vld <= r_cur_vld | r_fill[1];
  end

  assign w_cur_vld = r_cur_vld;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_bit;

      // The first valid synchronised sample loads directly so a pin held
      // high through reset is not mistaken for a rising edge.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
          r_bit <= 1'b0;
        end else if (!r_cur_vld) begin
          r_cnt <= '0;
          r_bit <= r_sync2[i];
        end else if (r_sync2[i] == r_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
          r_cnt <= '0;
          r_bit <= r_sync2[i];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_cur[i] = r_bit;
    end
  endgenerate
`else
  assign w_cur     = r_sync2;
  assign w_cur_vld = r_fill[1];
`endif

  assign w_rise  = w_cur & ~r_prev;
  assign w_fall  = ~w_cur & r_prev;
  assign w_event = r_primed ? ((r_edge & w_rise) | (~r_edge & w_fall)) : '0;

  always_comb begin
    w_rd = '0;
    case (w_sel)
      c_A_OUT:    w_rd[WIDTH-1:0] = r_out;
      c_A_DIR:    w_rd[WIDTH-1:0] = r_dir;
      c_A_IN:     w_rd[WIDTH-1:0] = w_cur;
      c_A_MASK:   w_rd[WIDTH-1:0] = r_mask;
      c_A_EDGE:   w_rd[WIDTH-1:0] = r_edge;
      c_A_STATUS: w_rd[WIDTH-1:0] = r_status;
      default:    w_rd = '0;
    endcase
  end

  // Event set takes priority over a same-cycle W1C on the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out    <= OUT_RESET;
      r_dir    <= '0;
      r_mask   <= '0;
      r_edge   <= '0;
      r_status <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ready  <= w_accept;
      r_rdata  <= w_accept ? w_rd : 32'h0;
      r_irq    <= |(r_status & r_mask);
      r_status <= (r_status & ~w_w1c) | w_event;
      if (w_write) begin
        case (w_sel)
          c_A_OUT:  r_out  <= merge(r_out,  w_wdata, w_wmask);
          c_A_DIR:  r_dir  <= merge(r_dir,  w_wdata, w_wmask);
          c_A_MASK: r_mask <= merge(r_mask, w_wdata, w_wmask);
          c_A_EDGE: r_edge <= merge(r_edge, w_wdata, w_wmask);
          default:  ;
        endcase
      end
    end
  end

  assign bus_ready = r_ready;
  assign bus_rdata = r_rdata;
  assign pin_out   = r_out;
  assign pin_oe    = r_dir;
  assign irq       = r_irq;

endmodule
`default_nettype wire
